regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's 2-read/1-write register file.
- Adds a second write port for long-latency units (mult/div, future load-miss path).
- Adds a per-register pending scoreboard, an outstanding-reservation limit and a registered write-conflict flag.
- Sits between decode (reads, reservations) and the two writeback paths; the hazard/stall unit consumes rbusy1/rbusy2 and rsv_ready.

Parameters:
N_BIT, 32, data width of each register
REG_ADDR_SIZE, 5, address width; register count = 2**REG_ADDR_SIZE
REG_ZERO, 0, hard-wired zero register index
MAX_PEND, 4, max simultaneously pending registers (1..2**REG_ADDR_SIZE-1)

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
raddr1, raddr2  input  REG_ADDR_SIZE  read addresses
rdata1, rdata2  output  N_BIT  read data, combinational
rbusy1, rbusy2  output  1  read register has pending long-latency write
waddr  input  REG_ADDR_SIZE  primary (single-cycle) write address
wdata  input  N_BIT  primary write data
reg_write  input  1  primary write enable
lwaddr  input  REG_ADDR_SIZE  long-latency writeback address
lwdata  input  N_BIT  long-latency writeback data
lreg_write  input  1  long-latency writeback enable
rsv_addr  input  REG_ADDR_SIZE  destination to reserve
rsv_valid  input  1  reservation request
rsv_ready  output  1  reservation will be accepted this cycle, combinational
pend_count  output  REG_ADDR_SIZE  number of pending registers
wr_conflict  output  1  registered one-cycle pulse: a primary write was dropped

Behaviour:
- Reset (async, nReset low): all registers 0, all pending bits 0, pend_count 0, wr_conflict 0. Effect is immediate and overrides any in-flight reservation.
- Reads:
  - Index REG_ZERO reads 0 and rbusyN 0.
  - Otherwise rdataN = mem[raddrN] and rbusyN = pending[raddrN].
  - Bypass rules are given under Optional Feature.
- Writes to REG_ZERO on either port are ignored. They never set wr_conflict.
- Long write (lreg_write):
  - Always performed at the rising edge.
  - Clears pending[lwaddr] if set.
- Primary write (reg_write):
  - Performed at the rising edge unless pending[waddr]=1, or lreg_write=1 with lwaddr==waddr.
  - In either blocked case the write is dropped and wr_conflict=1 in the following cycle only.
  - When both ports target the same address, the long write wins.
- Reservation accepted when rsv_valid & rsv_ready & rsv_addr!=REG_ZERO; sets pending[rsv_addr] at the edge.
- rsv_ready = (pend_count < MAX_PEND or a pending-clearing long write occurs this cycle) and (pending[rsv_addr]=0 or lreg_write=1 with lwaddr==rsv_addr).
  - rsv_valid to REG_ZERO: rsv_ready=1, no state change.
- Same-cycle clear and reserve of the same address: pending stays 1, because the new reservation supersedes the completed one.
- pend_count next = pend_count + accepted_reservation - clear.
  - clear = 1 only when lreg_write hits a set pending bit.
  - Long write to a non-pending register: no count change.
- Latency: writes and scoreboard updates are visible 1 cycle after the edge; reads are 0-cycle combinational.
- pend_count never exceeds MAX_PEND and never underflows.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an effective write in the same cycle returns that write's data.
  - Priority is lwdata over wdata.
  - A dropped primary write is not bypassed.
  - rbusyN is 0 when the matching lreg_write clears that register this cycle, unless the register is re-reserved the same cycle.
- Undefined:
  - Reads return the pre-edge register contents.
  - rbusyN reflects the pre-edge pending bit.

Test Plan:
- Reset and zero register: pulse nReset low mid-run with 3 registers pending -> all rdata 0, pend_count 0, rsv_ready 1. Write 0xDEADBEEF to r0 -> reading r0 returns 0.
- Basic write/read: reg_write r5=0x12345678 -> next cycle rdata1(r5)=0x12345678. With REGFILE_BYPASS_EN, same cycle rdata1=0x12345678.
- Scoreboard: reserve r8 -> rbusy(r8)=1, pend_count 1. Primary write r8=0x1 -> dropped, wr_conflict high exactly one cycle, r8 unchanged. lreg_write r8=0xCAFE -> r8=0xCAFE, rbusy 0, pend_count 0.
- Limit: reserve r1..r4 (MAX_PEND=4) -> rsv_ready 0 for r6. Same cycle as lreg_write r2 -> r6 accepted, pend_count stays 4.
- Same-address collisions: reg_write and lreg_write both to r9 (0x11 / 0x22) -> r9=0x22, wr_conflict 1. Clear and reserve r9 in the same cycle -> r9 pending, pend_count unchanged.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 2R/2W register file with pending-write scoreboard; optional
//            same-cycle write bypass when REGFILE_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int unsigned N_BIT         = 32,
  parameter int unsigned REG_ADDR_SIZE = 5,
  parameter int unsigned REG_ZERO      = 0,
  parameter int unsigned MAX_PEND      = 4
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic [REG_ADDR_SIZE-1:0] raddr1,
  input  logic [REG_ADDR_SIZE-1:0] raddr2,
  output logic [N_BIT-1:0]         rdata1,
  output logic [N_BIT-1:0]         rdata2,
  output logic                     rbusy1,
  output logic                     rbusy2,
  input  logic [REG_ADDR_SIZE-1:0] waddr,
  input  logic [N_BIT-1:0]         wdata,
  input  logic                     reg_write,
  input  logic [REG_ADDR_SIZE-1:0] lwaddr,
  input  logic [N_BIT-1:0]         lwdata,
  input  logic                     lreg_write,
  input  logic [REG_ADDR_SIZE-1:0] rsv_addr,
  input  logic                     rsv_valid,
  output logic                     rsv_ready,
  output logic [REG_ADDR_SIZE-1:0] pend_count,
  output logic                     wr_conflict
);

  localparam int unsigned                c_NREG     = 2**REG_ADDR_SIZE;
  localparam logic [REG_ADDR_SIZE-1:0]   c_ZERO     = REG_ADDR_SIZE'(REG_ZERO);
  localparam logic [REG_ADDR_SIZE-1:0]   c_MAX_PEND = REG_ADDR_SIZE'(MAX_PEND);

  logic [N_BIT-1:0]         mem_q [c_NREG];
  logic [c_NREG-1:0]        pend_q, pend_d;
  logic [REG_ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic                     conflict_q, conflict_d;

  logic w_lw_eff, w_clear, w_pw_req, w_pw_block, w_pw_eff;
  logic w_slot, w_free, w_accept;

  assign w_lw_eff   = lreg_write && (lwaddr != c_ZERO);
  assign w_clear    = w_lw_eff && pend_q[lwaddr];
  assign w_pw_req   = reg_write && (waddr != c_ZERO);
  // A primary write loses to both an outstanding reservation and a same-address long write
  assign w_pw_block = pend_q[waddr] || (lreg_write && (lwaddr == waddr));
  assign w_pw_eff   = w_pw_req && !w_pw_block;
  assign conflict_d = w_pw_req && w_pw_block;

  assign w_slot    = (cnt_q < c_MAX_PEND) || w_clear;
  assign w_free    = !pend_q[rsv_addr] || (lreg_write && (lwaddr == rsv_addr));
  assign rsv_ready = (rsv_addr == c_ZERO) || (w_slot && w_free);
  assign w_accept  = rsv_valid && rsv_ready && (rsv_addr != c_ZERO);

  // Reserve is applied after clear so a re-reservation keeps the bit set
  always_comb begin
    pend_d = pend_q;
    if (w_clear)  pend_d[lwaddr]   = 1'b0;
    if (w_accept) pend_d[rsv_addr] = 1'b1;
  end

  assign cnt_d = cnt_q + REG_ADDR_SIZE'(w_accept) - REG_ADDR_SIZE'(w_clear);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < c_NREG; i++) mem_q[i] <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (w_pw_eff) mem_q[waddr]  <= wdata;
      if (w_lw_eff) mem_q[lwaddr] <= lwdata;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  logic [1:0][REG_ADDR_SIZE-1:0] w_raddr;
  logic [1:0][N_BIT-1:0]         w_rdata;
  logic [1:0]                    w_rbusy;

  assign w_raddr = {raddr2, raddr1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [N_BIT-1:0] w_rd;
    logic             w_rb;
    always_comb begin
      w_rd = mem_q[w_raddr[gi]];
      w_rb = pend_q[w_raddr[gi]];
`ifdef REGFILE_BYPASS_EN
      if (w_pw_eff && (waddr == w_raddr[gi])) w_rd = wdata;
      if (w_lw_eff && (lwaddr == w_raddr[gi])) begin
        w_rd = lwdata;
        if (!(w_accept && (rsv_addr == w_raddr[gi]))) w_rb = 1'b0;
      end
`endif
      if (w_raddr[gi] == c_ZERO) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
    end
    assign w_rdata[gi] = w_rd;
    assign w_rbusy[gi] = w_rb;
  end

  assign rdata1      = w_rdata[0];
  assign rdata2      = w_rdata[1];
  assign rbusy1      = w_rbusy[0];
  assign rbusy2      = w_rbusy[1];
  assign pend_count  = cnt_q;
  assign wr_conflict = conflict_q;

endmodule

`default_nettype wire
